// File: rtl/bitwise_shift_pipe.sv
// bitwise_shift_pipe: pipelined logarithmic shifter (SLL / SRL / SRA / ROR).
// One 2:1 select stage per shift-amount bit, registered after each stage,
// valid/ready handshake on both sides with a single global advance.
// Optional feature macro: BITWISE_SHIFT_ROTATE_EN enables ROR on op 2'b11;
// without it op 2'b11 behaves exactly as SRL.
module bitwise_shift_pipe #(
    parameter  int N = 8,
    localparam int S = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [S-1:0] in_amt,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    // Shift one operand by a fixed distance according to the operation.
    function automatic logic [N-1:0] shift_by(input logic [N-1:0] d,
                                              input logic [1:0]   op,
                                              input logic         sgn,
                                              input int           sh);
        logic [N-1:0] r;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            OP_SRA:  r = (d >> sh) | (~(ONES >> sh) & {N{sgn}});
`ifdef BITWISE_SHIFT_ROTATE_EN
            OP_ROR:  r = (d >> sh) | (d << (N - sh));
`else
            OP_ROR:  r = d >> sh;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Stage registers
    logic [N-1:0] data_q  [S];
    logic [N-1:0] data_d  [S];
    logic [1:0]   op_q    [S];
    logic [1:0]   op_d    [S];
    logic [S-1:0] amt_q   [S];
    logic [S-1:0] amt_d   [S];
    logic         sign_q  [S];
    logic         sign_d  [S];
    logic         valid_q [S];
    logic         valid_d [S];

    // Per-stage sources (stage 0 fed by the input port, stage k by stage k-1)
    logic [N-1:0] src_data_s  [S];
    logic [1:0]   src_op_s    [S];
    logic [S-1:0] src_amt_s   [S];
    logic         src_sign_s  [S];
    logic         src_valid_s [S];

    logic advance_s;
    logic in_ready_s;
    logic accept_s;

    // Handshake and next-state computation for every stage.
    always_comb begin
        advance_s  = !valid_q[S-1] || out_ready;
        in_ready_s = advance_s && !rst;
        accept_s   = in_valid && in_ready_s;

        src_data_s[0]  = in_data;
        src_op_s[0]    = in_op;
        src_amt_s[0]   = in_amt;
        src_sign_s[0]  = in_data[N-1];
        src_valid_s[0] = accept_s;
        for (int k = 1; k < S; k++) begin
            src_data_s[k]  = data_q[k-1];
            src_op_s[k]    = op_q[k-1];
            src_amt_s[k]   = amt_q[k-1];
            src_sign_s[k]  = sign_q[k-1];
            src_valid_s[k] = valid_q[k-1];
        end

        for (int k = 0; k < S; k++) begin
            data_d[k]  = data_q[k];
            op_d[k]    = op_q[k];
            amt_d[k]   = amt_q[k];
            sign_d[k]  = sign_q[k];
            valid_d[k] = valid_q[k];
            if (advance_s) begin
                valid_d[k] = src_valid_s[k];
                // Bubbles leave the data registers untouched so out_data
                // keeps showing the last real result.
                if (src_valid_s[k]) begin
                    op_d[k]   = src_op_s[k];
                    amt_d[k]  = src_amt_s[k];
                    sign_d[k] = src_sign_s[k];
                    if (src_amt_s[k][k]) begin
                        data_d[k] = shift_by(src_data_s[k], src_op_s[k],
                                             src_sign_s[k], 1 << k);
                    end else begin
                        data_d[k] = src_data_s[k];
                    end
                end else begin
                    data_d[k] = data_q[k];
                end
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Stage registers with synchronous reset that empties the pipe.
    always_ff @(posedge clk) begin
        for (int k = 0; k < S; k++) begin
            if (rst) begin
                data_q[k]  <= {N{1'b0}};
                op_q[k]    <= 2'b00;
                amt_q[k]   <= {S{1'b0}};
                sign_q[k]  <= 1'b0;
                valid_q[k] <= 1'b0;
            end else begin
                data_q[k]  <= data_d[k];
                op_q[k]    <= op_d[k];
                amt_q[k]   <= amt_d[k];
                sign_q[k]  <= sign_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q[S-1];
    assign out_data  = data_q[S-1];

endmodule

// File: doc/bitwise_shift_pipe.md
# bitwise_shift_pipe

Parametrised, pipelined logarithmic shifter that applies a selectable shift operation to an N-bit operand. The datapath is one 2:1 select stage per shift-amount bit, with a register after each stage and a valid/ready handshake on both sides. It is the sequential successor to the single-stage shift select in the BitWise unit and feeds the ALU result path of BasicCombinationalLogic.

## Interface
Parameters:
- N, 8, operand and result width in bits; power of two, N >= 2.
- S, $clog2(N), number of stages and width of the shift amount; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request present on in_op/in_amt/in_data.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- in_amt  input  S  shift amount, 0..N-1.
- in_data  input  N  operand.
- out_valid  output  1  result present on out_data.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  N  shifted result.

## Operation
- Stage k (0..S-1) shifts its operand by 2^k when amount bit k is 1, and passes it through otherwise. Each stage registers data, op, remaining amount bits, the SRA sign bit (in_data[N-1] captured at stage 0), and a valid bit.
- Fill rules:
  - SLL: zeros enter at the LSBs.
  - SRL: zeros enter at the MSBs.
  - SRA: the captured sign bit enters at the MSBs.
  - ROR: bits shifted out of the LSB end re-enter at the MSBs.
- Amount 0: out_data equals in_data for every op.
- Results are exact modulo 2^N; no overflow flag.
- Pipeline advance: advance = !out_valid || out_ready. It is global; all stages move together or hold.
- in_ready = advance (combinational). A request is accepted on a cycle with in_valid && in_ready.
- Bubbles are not collapsed. An empty stage still occupies a slot.
- During a stall, every stage register and out_data hold their values. out_valid stays asserted and out_data is stable until out_ready is sampled high.
- in_data/in_op/in_amt are ignored when in_valid is low or in_ready is low.

## Timing
- Reset values: all stage valid bits 0, so out_valid = 0; out_data = 0; all stage data registers 0. in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation: all in-flight requests are discarded. No result for them ever appears, and the next request sees an empty pipe.
- While rst is high, in_ready is forced 0.
- Latency: a request accepted at rising edge t is presented with out_valid = 1 after edge t+S-1, i.e. S cycles from acceptance (3 for N = 8), when there are no stalls.
- Each stall cycle adds exactly one cycle of latency.
- Throughput: one result per cycle when out_ready is held high.
- Simultaneous out handshake and new acceptance in the same cycle is legal and required for full throughput.

## Configuration
- Macro BITWISE_SHIFT_ROTATE_EN.
- Defined: op 11 performs ROR as above.
- Undefined: the ROR wrap logic is not compiled; op 11 behaves exactly as SRL.
- The macro has no effect on port list, latency or handshake.

## Test plan
All cases use N = 8, S = 3.
- Reset then idle: rst high 2 cycles, then low -> out_valid 0, out_data 0x00, in_ready 1 throughout idle.
- Basic ops, out_ready high:
  - SLL 0x81 amt 1 -> 0x02.
  - SRL 0x80 amt 3 -> 0x10.
  - SRA 0x80 amt 3 -> 0xF0.
  - SRA 0x40 amt 3 -> 0x08.
  - Each appears exactly 3 cycles after acceptance.
- Rotate:
  - ROR 0x01 amt 1 -> 0x80 with BITWISE_SHIFT_ROTATE_EN.
  - Same request -> 0x00 without the macro.
  - ROR 0xA5 amt 4 -> 0x5A with the macro.
- Throughput: 8 back-to-back SLL 0x01 amt 0..7 with out_ready high -> outputs 0x01, 0x02 … 0x80 on 8 consecutive cycles, no gaps.
- Backpressure: fill the pipe with 3 requests, drop out_ready for 5 cycles.
  - in_ready is 0 and out_data is stable for all 5 cycles.
  - On release, the 3 results emerge in order with none lost or duplicated.
- Reset mid-flight: accept 2 requests, assert rst one cycle later -> no out_valid for either request. A subsequent SRL 0xFF amt 7 returns 0x01 after 3 cycles.
